// File: rtl/vga_sync_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_monitor
// Brief    : Receive-side VGA timing checker. Rebuilds the pixel/line position
//            from hsync/vsync, measures line/frame/pulse timing, and reports
//            lock, timing errors and an active-video window.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int H_START     = 144,
  parameter int V_START     = 35,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] hcount_rx,
  output logic [9:0] vcount_rx,
  output logic [9:0] meas_h_total,
  output logic [9:0] meas_v_total,
  output logic       video_active,
  output logic       locked,
  output logic       line_err,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int         GW        = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0] CNT_MAX   = 10'd1023;
  localparam logic [9:0] H_TOTAL_W = 10'(H_TOTAL);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] H_START_W = 10'(H_START);
  localparam logic [9:0] H_END_W   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_START_W = 10'(V_START);
  localparam logic [9:0] V_END_W   = 10'(V_START + V_ACTIVE);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          hs_q, vs_q;
  logic          hfall, hrise, vfall, vrise;
  logic [9:0]    hcount_inc, vcount_inc, vwidth;
  logic          hsync_lost, checking, skip_line, dirty;
  logic          line_bad, frame_bad, any_err, lock_now, enter_check;
  logic [GW-1:0] good_cnt, good_next;
  logic          h_in, v_in;

  assign hfall = hs_q & ~hsync;
  assign hrise = ~hs_q & hsync;
  assign vfall = vs_q & ~vsync;
  assign vrise = ~vs_q & vsync;

  // Saturating +1; also serves as the "old count + 1" measurement value.
  assign hcount_inc = (hcount_rx == CNT_MAX) ? CNT_MAX : hcount_rx + 10'd1;
  assign vcount_inc = (vcount_rx == CNT_MAX) ? CNT_MAX : vcount_rx + 10'd1;

  // A saturated line counter means hsync has gone away; no checks then.
  assign hsync_lost = (hcount_rx == CNT_MAX);
  assign checking   = ((state == CHECK) || (state == LOCKED)) && !hsync_lost;

  // The first line measured after entering CHECK may be partial, so skip it.
  assign line_bad  = checking &&
                     ((hfall && !skip_line && (hcount_inc != H_TOTAL_W)) ||
                      (hrise && (hcount_inc != H_SYNC_W)));
  // A line error detected on the vfall cycle still belongs to the ending frame.
  assign frame_bad = checking && vfall &&
                     ((vcount_inc != V_TOTAL_W) || (vwidth != V_SYNC_W) ||
                      dirty || line_bad);

  assign any_err     = line_err || frame_err;
  assign good_next   = good_cnt + 1'b1;
  assign lock_now    = (state == CHECK) && checking && vfall && !frame_bad &&
                       !any_err && (good_next == GW'(LOCK_FRAMES));
  assign enter_check = (state_nx == CHECK) && (state != CHECK);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= SEARCH;
    else     state <= state_nx;
  end

  // Next-state, lock flag and active-video window.
  always_comb begin
    state_nx     = state;
    locked       = 1'b0;
    h_in         = 1'b0;
    v_in         = 1'b0;
    video_active = 1'b0;
    case (state)
      SEARCH:  if (vfall)    state_nx = CHECK;
      CHECK:   if (lock_now) state_nx = LOCKED;
      LOCKED:  if (any_err)  state_nx = CHECK;
      default:               state_nx = SEARCH;
    endcase
    if (hsync_lost) state_nx = SEARCH;
    locked       = (state == LOCKED);
    h_in         = (hcount_rx >= H_START_W) && (hcount_rx < H_END_W);
    v_in         = (vcount_rx >= V_START_W) && (vcount_rx < V_END_W);
    video_active = locked && h_in && v_in;
  end

  // Sync sampling, position counters and timing measurements.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      hcount_rx    <= '0;
      vcount_rx    <= '0;
      meas_h_total <= '0;
      meas_v_total <= '0;
      vwidth       <= '0;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
      if (hfall) begin
        hcount_rx    <= '0;
        meas_h_total <= hcount_inc;
      end else begin
        hcount_rx <= hcount_inc;
      end
      if (vfall) begin
        vcount_rx    <= '0;
        meas_v_total <= vcount_inc;
      end else if (hfall) begin
        vcount_rx <= vcount_inc;
      end
      if (vrise) vwidth <= vcount_inc;
    end
  end

  // Error pulses, frame bookkeeping and the saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      skip_line <= 1'b0;
      dirty     <= 1'b0;
      good_cnt  <= '0;
      err_count <= '0;
    end else begin
      line_err  <= line_bad;
      frame_err <= frame_bad;

      if (enter_check) skip_line <= 1'b1;
      else if (hfall)  skip_line <= 1'b0;

      if ((state == SEARCH) || vfall) dirty <= 1'b0;
      else if (line_bad)              dirty <= 1'b1;

      if ((state != CHECK) || any_err)             good_cnt <= '0;
      else if (checking && vfall && !frame_bad)    good_cnt <= good_next;

      if ((state == LOCKED) && any_err && (err_count != 8'd255))
        err_count <= err_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_monitor
// Brief    : Directed bench for vga_sync_monitor. The DUT runs with a scaled
//            raster (40 clocks/line, 6-clock hsync, 12 lines/frame, 2-line
//            vsync, 24x6 active window at h=10, v=3) so many frames fit in a
//            short run; the 1023 saturation limit is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_monitor;

  logic       clk = 1'b0;
  logic       rst, hsync, vsync;
  logic [9:0] hcount_rx, vcount_rx, meas_h_total, meas_v_total;
  logic       video_active, locked, line_err, frame_err;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;
  int act_cnt, first_h, first_v, fall_h, le_cnt, fe_cnt;
  int le_line, le_pos, v_start, h_end_odd;
  logic prev_act = 1'b0;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_TOTAL(40), .H_SYNC(6), .V_TOTAL(12), .V_SYNC(2),
    .H_START(10), .V_START(3), .H_ACTIVE(24), .V_ACTIVE(6),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .hcount_rx(hcount_rx), .vcount_rx(vcount_rx),
    .meas_h_total(meas_h_total), .meas_v_total(meas_v_total),
    .video_active(video_active), .locked(locked),
    .line_err(line_err), .frame_err(frame_err), .err_count(err_count)
  );

  // One clock: drive inputs, let the DUT sample them, observe 1 ns later.
  task automatic cyc(input logic hs, input logic vs);
    hsync = hs;
    vsync = vs;
    @(posedge clk);
    #1;
    if (video_active && !prev_act && act_cnt == 0) begin
      first_h = hcount_rx;
      first_v = vcount_rx;
    end
    if (!video_active && prev_act) fall_h = hcount_rx;
    if (video_active) act_cnt++;
    prev_act = video_active;
    if (line_err)  le_cnt++;
    if (frame_err) fe_cnt++;
  endtask

  task automatic clear_mon();
    act_cnt = 0; le_cnt = 0; fe_cnt = 0;
    first_h = -1; first_v = -1; fall_h = -1;
    le_line = -1; le_pos = -1; v_start = -1; h_end_odd = -1;
  endtask

  // One frame; hsync and vsync fall together at line 0. One line may differ.
  task automatic drive_frame(input int odd_line, input int odd_len, input int odd_hlow);
    int len, hlow;
    clear_mon();
    for (int l = 0; l < 12; l++) begin
      len  = (l == odd_line) ? odd_len  : 40;
      hlow = (l == odd_line) ? odd_hlow : 6;
      for (int i = 0; i < len; i++) begin
        cyc((i >= hlow), (l >= 2));
        if (l == 0 && i == 0) v_start = vcount_rx;
        if (l == odd_line && i == len - 1) h_end_odd = hcount_rx;
        if (line_err) begin le_line = l; le_pos = i; end
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    total++; if (hcount_rx !== 10'd0) begin bad++; $display("FAIL reset_hcount: got %0d want 0", hcount_rx); end
    total++; if (vcount_rx !== 10'd0) begin bad++; $display("FAIL reset_vcount: got %0d want 0", vcount_rx); end
    total++; if (meas_h_total !== 10'd0 || meas_v_total !== 10'd0) begin bad++; $display("FAIL reset_meas: got %0d/%0d want 0/0", meas_h_total, meas_v_total); end
    total++; if ({video_active, locked, line_err, frame_err} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {video_active, locked, line_err, frame_err}); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
    #4 rst = 1'b0;
  endtask

  task automatic test_lock();
    repeat (5) cyc(1'b1, 1'b1);
    total++; if (hcount_rx !== 10'd5) begin bad++; $display("FAIL idle_hcount: got %0d want 5", hcount_rx); end
    drive_frame(-1, 0, 0);
    drive_frame(-1, 0, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early: got %0d want 0", locked); end
    drive_frame(-1, 0, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_locked: got %0d want 1", locked); end
    total++; if (meas_h_total !== 10'd40) begin bad++; $display("FAIL lock_meas_h: got %0d want 40", meas_h_total); end
    total++; if (meas_v_total !== 10'd12) begin bad++; $display("FAIL lock_meas_v: got %0d want 12", meas_v_total); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL lock_errcnt: got %0d want 0", err_count); end
    total++; if (le_cnt !== 0 || fe_cnt !== 0) begin bad++; $display("FAIL lock_pulses: got le=%0d fe=%0d want 0/0", le_cnt, fe_cnt); end
  endtask

  task automatic test_video_active();
    drive_frame(-1, 0, 0);
    total++; if (act_cnt !== 144) begin bad++; $display("FAIL va_count: got %0d want 144", act_cnt); end
    total++; if (first_h !== 10 || first_v !== 3) begin bad++; $display("FAIL va_rise: got h=%0d v=%0d want h=10 v=3", first_h, first_v); end
    total++; if (fall_h !== 34) begin bad++; $display("FAIL va_fall: got h=%0d want 34", fall_h); end
    total++; if (v_start !== 0) begin bad++; $display("FAIL coincident_vcount: got %0d want 0", v_start); end
    total++; if (le_cnt !== 0 || fe_cnt !== 0 || locked !== 1'b1) begin bad++; $display("FAIL va_clean: got le=%0d fe=%0d lock=%0d want 0/0/1", le_cnt, fe_cnt, locked); end
  endtask

  task automatic test_long_line();
    drive_frame(5, 41, 6);
    total++; if (le_cnt !== 1) begin bad++; $display("FAIL long_le_count: got %0d want 1", le_cnt); end
    total++; if (le_line !== 6 || le_pos !== 0) begin bad++; $display("FAIL long_le_pos: got line=%0d pos=%0d want 6/0", le_line, le_pos); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL long_unlock: got %0d want 0", locked); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL long_errcnt: got %0d want 1", err_count); end
    total++; if (fe_cnt !== 0) begin bad++; $display("FAIL long_fe_early: got %0d want 0", fe_cnt); end
    drive_frame(-1, 0, 0);
    total++; if (fe_cnt !== 1 || le_cnt !== 0) begin bad++; $display("FAIL long_dirty_frame: got fe=%0d le=%0d want 1/0", fe_cnt, le_cnt); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL long_relock_a: got %0d want 0", locked); end
    drive_frame(-1, 0, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL long_relock_b: got %0d want 0", locked); end
    drive_frame(-1, 0, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL long_relock_c: got %0d want 1", locked); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL long_errcnt_hold: got %0d want 1", err_count); end
  endtask

  task automatic test_narrow_hsync();
    drive_frame(4, 40, 5);
    total++; if (le_cnt !== 1) begin bad++; $display("FAIL narrow_le_count: got %0d want 1", le_cnt); end
    total++; if (le_line !== 4 || le_pos !== 5) begin bad++; $display("FAIL narrow_le_pos: got line=%0d pos=%0d want 4/5", le_line, le_pos); end
    total++; if (locked !== 1'b0 || err_count !== 8'd2) begin bad++; $display("FAIL narrow_unlock: got lock=%0d cnt=%0d want 0/2", locked, err_count); end
    drive_frame(-1, 0, 0);
    total++; if (fe_cnt !== 1 || le_cnt !== 0) begin bad++; $display("FAIL narrow_frame_err: got fe=%0d le=%0d want 1/0", fe_cnt, le_cnt); end
    drive_frame(-1, 0, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL narrow_goodcnt_reset: got %0d want 0", locked); end
    drive_frame(-1, 0, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL narrow_relock: got %0d want 1", locked); end
  endtask

  task automatic test_hsync_loss();
    drive_frame(3, 1106, 6);
    total++; if (h_end_odd !== 1023) begin bad++; $display("FAIL loss_saturate: got %0d want 1023", h_end_odd); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_unlock: got %0d want 0", locked); end
    total++; if (le_cnt !== 0 || fe_cnt !== 0) begin bad++; $display("FAIL loss_no_pulse: got le=%0d fe=%0d want 0/0", le_cnt, fe_cnt); end
    total++; if (err_count !== 8'd2) begin bad++; $display("FAIL loss_errcnt: got %0d want 2", err_count); end
    drive_frame(-1, 0, 0);
    total++; if (fe_cnt !== 0 || locked !== 1'b0) begin bad++; $display("FAIL loss_search_vfall: got fe=%0d lock=%0d want 0/0", fe_cnt, locked); end
    drive_frame(-1, 0, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_relock_b: got %0d want 0", locked); end
    drive_frame(-1, 0, 0);
    total++; if (locked !== 1'b1 || meas_h_total !== 10'd40 || meas_v_total !== 10'd12) begin bad++; $display("FAIL loss_relock_c: got lock=%0d h=%0d v=%0d want 1/40/12", locked, meas_h_total, meas_v_total); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 40; i++) cyc((i >= 6), (l >= 2));
    total++; if (locked !== 1'b1 || vcount_rx !== 10'd3) begin bad++; $display("FAIL mid_pre: got lock=%0d v=%0d want 1/3", locked, vcount_rx); end
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    total++; if (hcount_rx !== 10'd0 || vcount_rx !== 10'd0) begin bad++; $display("FAIL mid_counts: got h=%0d v=%0d want 0/0", hcount_rx, vcount_rx); end
    total++; if (meas_h_total !== 10'd0 || meas_v_total !== 10'd0) begin bad++; $display("FAIL mid_meas: got %0d/%0d want 0/0", meas_h_total, meas_v_total); end
    total++; if ({video_active, locked, line_err, frame_err} !== 4'b0) begin bad++; $display("FAIL mid_flags: got %b want 0000", {video_active, locked, line_err, frame_err}); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL mid_errcnt: got %0d want 0", err_count); end
    rst = 1'b0;
    cyc(1'b1, 1'b1);
    total++; if (line_err !== 1'b0 || frame_err !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL mid_after: got le=%0d fe=%0d lock=%0d want 0/0/0", line_err, frame_err, locked); end
    total++; if (hcount_rx !== 10'd1) begin bad++; $display("FAIL mid_restart: got %0d want 1", hcount_rx); end
  endtask

  initial begin
    rst   = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    clear_mon();
    test_reset();
    test_lock();
    test_video_active();
    test_long_line();
    test_narrow_hsync();
    test_hsync_loss();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
